cdb_arbiter: RTL and testbench

Common-data-bus arbiter for the Tomasulo back end. Collects completed results from up to NUM_REQ execution units: integer, load/store, multiply, divide. Each result is held in a one-entry holding slot per unit. Exactly one result per cycle is broadcast on the CDB under round-robin priority. Per-unit ready signals let issue logic stall a unit whose previous result has not yet won the bus.

---
 rtl/cdb_arbiter.sv | 77 +++++++
 tb/tb_cdb_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin common-data-bus arbiter with a one-entry holding slot per execution unit
package cdb_pkg;
  typedef struct packed {
    logic [31:0] cdb_data;
    logic [5:0]  cdb_tag;
    logic        cdb_valid;
    logic        cdb_branch;
    logic        cdb_branch_taken;
  } cdb_bus_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  cdb_bus_t           req_cdb [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  input  logic               flush,
  output cdb_bus_t           cdb_out,
  output logic [NUM_REQ-1:0] grant
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  logic [NUM_REQ-1:0] r_slot_v;
  cdb_bus_t           r_slot_q [NUM_REQ];
  logic [IW-1:0]      r_last_g;
  logic [IW-1:0]      w_idx;
  logic [IW-1:0]      w_win;
  logic               w_found;
  logic               w_fire;
  // walk the slots starting just after the last winner; the first occupied one wins
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last_g;
    w_idx   = r_last_g;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      if (!w_found && r_slot_v[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end
  // drive the bus from the winning slot only; a flush silences the bus and all ready lines
  always_comb begin
    w_fire    = w_found && !flush;
    grant     = w_fire ? (NUM_REQ'(1) << w_win) : '0;
    cdb_out   = '0;
    if (w_fire) begin
      cdb_out           = r_slot_q[w_win];
      cdb_out.cdb_valid = 1'b1;
    end
    req_ready = flush ? '0 : (~r_slot_v | grant);
  end
  // capture accepted results, retire the granted slot and advance the round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_v <= '0;
      r_slot_q <= '{default: '0};
      r_last_g <= IW'(NUM_REQ - 1);
    end else if (flush) begin
      r_slot_v <= '0;
    end else begin
      if (w_fire) r_last_g <= w_win;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_cdb[i].cdb_valid && req_ready[i]) begin
          r_slot_v[i] <= 1'b1;
          r_slot_q[i] <= req_cdb[i];
        end else if (grant[i]) begin
          r_slot_v[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed tests of cdb_arbiter against a slot/rotating-priority model
module tb_cdb_arbiter;
  import cdb_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  cdb_bus_t req [N];
  logic [N-1:0] req_ready, grant;
  cdb_bus_t cdb_out;
  int n_cmp = 0, n_fail = 0;
  bit m_v [N];
  cdb_bus_t m_q [N] = '{default: '0};
  int m_last = N - 1;
  int uw, cw;
  logic [N-1:0] ur, exp_g;
  cdb_bus_t exp_o;
  cdb_bus_t sq [N][$];
  logic [N-1:0] lg [32];
  logic [N-1:0] lr [32];
  cdb_bus_t lo [32];
  int k = 0;

  cdb_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_cdb(req), .req_ready(req_ready),
    .flush(flush), .cdb_out(cdb_out), .grant(grant)
  );

  // free-running clock
  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cdb_bus_t mk(logic [31:0] d, logic [5:0] t, logic b, logic tk);
    mk = '{cdb_data: d, cdb_tag: t, cdb_valid: 1'b1, cdb_branch: b, cdb_branch_taken: tk};
  endfunction

  // winner = occupied slot with the smallest forward distance from the last winner
  function automatic int m_win();
    int best = -1, bd = N, d;
    for (int i = 0; i < N; i++) begin
      d = (i - m_last - 1 + 2 * N) % N;
      if (m_v[i] && d < bd) begin
        bd = d;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int w = m_win();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = !flush && (!m_v[i] || w == i);
    return r;
  endfunction

  // model state: one held result per unit plus the last winner
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_v[i] = 1'b0;
        m_q[i] = '0;
      end
      m_last = N - 1;
    end else if (flush) begin
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    end else begin
      uw = m_win();
      ur = m_ready();
      if (uw >= 0) m_last = uw;
      for (int i = 0; i < N; i++) begin
        if (req[i].cdb_valid && ur[i]) begin
          m_v[i] = 1'b1;
          m_q[i] = req[i];
        end else if (i == uw) begin
          m_v[i] = 1'b0;
        end
      end
    end
  end

  // compare every DUT output against the model mid-cycle
  always @(negedge clk) begin
    cw = m_win();
    exp_g = (flush || cw < 0) ? '0 : N'(1 << cw);
    exp_o = '0;
    if (!flush && cw >= 0) begin
      exp_o = m_q[cw];
      exp_o.cdb_valid = 1'b1;
    end
    chk("grant", grant, exp_g);
    chk("cdb_out", cdb_out, exp_o);
    chk("req_ready", req_ready, m_ready());
  end

  task automatic cyc();
    logic [N-1:0] acc;
    for (int i = 0; i < N; i++) req[i] = (sq[i].size() > 0) ? sq[i][0] : '0;
    @(negedge clk);
    lg[k] = grant;
    lo[k] = cdb_out;
    lr[k] = req_ready;
    for (int i = 0; i < N; i++) acc[i] = req[i].cdb_valid && req_ready[i];
    k++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) void'(sq[i].pop_front());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < N; i++) sq[i].delete();
    @(negedge clk);
    chk("rst_valid", cdb_out.cdb_valid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 4'hf);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
  endtask

  initial begin
    int eg [8] = '{1, 2, 4, 8, 1, 2, 4, 8};
    int et [8] = '{1, 2, 3, 4, 9, 10, 11, 12};
    int bg [5] = '{1, 4, 8, 1, 1};
    int bt [5] = '{20, 22, 23, 21, 24};
    for (int i = 0; i < N; i++) req[i] = mk(32'h100 + i, 6'(i + 1), 1'b0, 1'b0);
    do_reset();
    sq[0].push_back(mk(32'h5, 6'd3, 1'b0, 1'b0));
    repeat (2) cyc();
    chk("first_grant0", lg[0], 0);
    chk("first_data", lo[1].cdb_data, 32'h5);
    chk("first_tag", lo[1].cdb_tag, 3);
    chk("first_valid", lo[1].cdb_valid, 1);
    chk("first_grant1", lg[1], 4'b0001);

    do_reset();
    for (int i = 0; i < N; i++) begin
      sq[i].push_back(mk(32'h200 + i, 6'(i + 1), 1'b0, 1'b0));
      sq[i].push_back(mk(32'h300 + i, 6'(i + 9), 1'b0, 1'b0));
    end
    repeat (10) cyc();
    for (int c = 0; c < 8; c++) begin
      chk("rr_grant", lg[c + 1], eg[c]);
      chk("rr_tag", lo[c + 1].cdb_tag, et[c]);
    end
    chk("rr_idle", lg[9], 0);
    for (int i = 0; i < N; i++) chk("rr_drained", sq[i].size(), 0);

    do_reset();
    for (int t = 10; t <= 12; t++) sq[0].push_back(mk(32'h400 + t, 6'(t), 1'b0, 1'b0));
    repeat (5) cyc();
    for (int c = 0; c < 3; c++) begin
      chk("b2b_ready", lr[c][0], 1);
      chk("b2b_tag", lo[c + 1].cdb_tag, 10 + c);
    end
    chk("b2b_idle", lg[4], 0);

    do_reset();
    sq[0].push_back(mk(32'h20, 6'd20, 1'b0, 1'b0));
    sq[0].push_back(mk(32'h21, 6'd21, 1'b0, 1'b0));
    sq[0].push_back(mk(32'h24, 6'd24, 1'b0, 1'b0));
    sq[2].push_back(mk(32'h22, 6'd22, 1'b0, 1'b0));
    sq[3].push_back(mk(32'h23, 6'd23, 1'b0, 1'b0));
    repeat (7) cyc();
    for (int c = 0; c < 5; c++) begin
      chk("bp_grant", lg[c + 1], bg[c]);
      chk("bp_tag", lo[c + 1].cdb_tag, bt[c]);
    end
    chk("bp_ready1", lr[1][0], 1);
    chk("bp_ready2", lr[2][0], 0);
    chk("bp_ready3", lr[3][0], 0);
    chk("bp_ready4", lr[4][0], 1);
    chk("bp_idle", lg[6], 0);

    do_reset();
    sq[0].push_back(mk(32'h77, 6'd7, 1'b1, 1'b1));
    sq[3].push_back(mk(32'h99, 6'd9, 1'b0, 1'b0));
    repeat (2) cyc();
    chk("br_tag", lo[1].cdb_tag, 7);
    chk("br_branch", lo[1].cdb_branch, 1);
    chk("br_taken", lo[1].cdb_branch_taken, 1);
    chk("br_grant", lg[1], 4'b0001);
    chk("br_ldst_ready", lr[1][1], 1);

    do_reset();
    sq[0].push_back(mk(32'h30, 6'd30, 1'b0, 1'b0));
    sq[2].push_back(mk(32'h32, 6'd32, 1'b0, 1'b0));
    sq[3].push_back(mk(32'h33, 6'd33, 1'b0, 1'b0));
    cyc();
    sq[1].push_back(mk(32'h31, 6'd31, 1'b0, 1'b0));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    sq[1].delete();
    repeat (2) cyc();
    chk("fl_valid", lo[1].cdb_valid, 0);
    chk("fl_ready", lr[1], 0);
    chk("fl_grant", lg[1], 0);
    chk("fl_after_grant", lg[2], 0);
    chk("fl_after_valid", lo[2].cdb_valid, 0);
    chk("fl_no_capture", lg[3], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
